// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared op codes, FSM state encodings and default width for the HI/LO sequencer,
// so the decoder, ALU control and this block agree on one set of codes.
package hilo_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Issue/result bundle between the pipeline control and the HI/LO sequencer.
interface hilo_muldiv_seq_if #(parameter int width = hilo_pkg::WIDTH_DEFAULT);

    logic             start;
    logic [2:0]       op;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic [width-1:0] hi;
    logic [width-1:0] lo;
    logic             busy;
    logic             done;

    modport master (output start, op, A, B, input hi, lo, busy, done);
    modport slave  (input start, op, A, B, output hi, lo, busy, done);

endinterface

// File: rtl/hilo_muldiv_seq_step.sv
// One radix-2 iteration shared by the shift-add multiplier and the restoring divider.
module muldiv_step
    import hilo_pkg::*;
#(
    parameter int width = WIDTH_DEFAULT
) (
    input  logic [2*width-1:0] acc,
    input  logic [width-1:0]   operand,
    input  logic               is_div,
    output logic [2*width-1:0] acc_next
);

    logic [width:0] mul_sum;
    logic [width:0] rem_shift;
    logic [width:0] rem_diff;
    logic           rem_ge;

    // MUL keeps the carry of the upper-half add so the right shift never loses it.
    always_comb begin
        mul_sum   = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, operand} : {(width+1){1'b0}});
        rem_shift = acc[2*width-1:width-1];
        rem_ge    = (rem_shift >= {1'b0, operand});
        rem_diff  = rem_shift - {1'b0, operand};
        acc_next  = {mul_sum, acc[width-1:1]};
        if (is_div) begin
            if (rem_ge) begin
                acc_next = {rem_diff[width-1:0], acc[width-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[width-1:0], acc[width-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning the architectural HI/LO registers.
module hilo_muldiv_seq
    import hilo_pkg::*;
#(
    parameter int width = WIDTH_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    hilo_muldiv_seq_if.slave bus
);

    localparam int CW = $clog2(width + 1);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*width-1:0] acc, acc_next;
    logic [width-1:0]   operand;
    logic [width-1:0]   hi_q, lo_q;
    logic               is_div, neg_res, neg_rem, div_zero, done_q;

    logic               op_signed, op_is_div, issue_md, last_step;
    logic [width-1:0]   a_abs, b_abs;
    logic [2*width-1:0] prod_fix;
    logic [width-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        op_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        issue_md  = (state == ST_IDLE) && bus.start &&
                    ((bus.op == OP_MULT) || (bus.op == OP_MULTU) || op_is_div);
        a_abs     = (op_signed && bus.A[width-1]) ? -bus.A : bus.A;
        b_abs     = (op_signed && bus.B[width-1]) ? -bus.B : bus.B;
        last_step = (cnt == CW'(width - 1));
    end

    muldiv_step #(.width(width)) u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (is_div),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (issue_md)  state_next = ST_CALC;
            ST_CALC: if (last_step) state_next = ST_FIX;
            ST_FIX:                 state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Magnitudes are captured at issue, so A/B may change freely while the op runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (issue_md) begin
            cnt      <= '0;
            acc      <= op_is_div ? {{width{1'b0}}, a_abs} : {{width{1'b0}}, b_abs};
            operand  <= op_is_div ? b_abs : a_abs;
            is_div   <= op_is_div;
            neg_res  <= op_signed && (bus.A[width-1] ^ bus.B[width-1]);
            neg_rem  <= op_signed && bus.A[width-1];
            div_zero <= op_is_div && (bus.B == '0);
        end else if (state == ST_CALC) begin
            cnt <= cnt + 1'b1;
            acc <= acc_next;
        end
    end

    // Divide by zero: quotient forced to all ones; remainder re-signed gives back A.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[width-1:0] : acc[width-1:0];
        if (div_zero) quo_fix = '1;
        rem_fix  = neg_rem ? -acc[2*width-1:width] : acc[2*width-1:width];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_FIX);
            if (state == ST_FIX) begin
                if (is_div) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[2*width-1:width];
                    lo_q <= prod_fix[width-1:0];
                end
            end else if ((state == ST_IDLE) && bus.start) begin
                if (bus.op == OP_MTHI) hi_q <= bus.A;
                if (bus.op == OP_MTLO) lo_q <= bus.A;
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Scoreboard bench for hilo_muldiv_seq: expected HI/LO pushed at issue, popped on done.
module tb_hilo_muldiv_seq;
    import hilo_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_muldiv_seq_if #(.width(32)) bus ();

    hilo_muldiv_seq #(.width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [63:0] expQ[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == OP_MULT)  return sa * sb;
        if (op == OP_MULTU) return ua * ub;
        if (b == 32'd0)     return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one issue across a single edge; A/B are scrambled afterwards on purpose.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        if (op <= OP_DIVU && !bus.busy) expQ.push_back(model(op, a, b));
        tick();
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic waitDone(input string tag, output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) checkOutput({tag, " timeout"}, 64'(bus.done), 64'd1);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n, busyCycles;
        applyStimulus(op, a, b);
        busyCycles = bus.busy ? 1 : 0;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
            if (bus.busy) busyCycles++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'd33);
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'd33);
        tick();
        checkOutput({tag, " done width"}, 64'(bus.done), 64'd0);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (expQ.size() == 0) checkOutput("unexpected done", 64'(bus.done), 64'd0);
            else                  checkOutput("result hi/lo", {bus.hi, bus.lo}, expQ.pop_front());
        end
    end

    initial begin
        int          n, doneCount;
        logic [31:0] oldLo;
        logic [63:0] firstRes;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        repeat (3) tick();
        checkOutput("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();

        runOp("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD);
        checkOutput("mult 7*-3 value", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        runOp("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        checkOutput("multu value", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2 value", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div overflow value", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        runOp("divu by zero", OP_DIVU, 32'h1234, 32'd0);
        checkOutput("divu by zero value", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
        runOp("div by zero neg", OP_DIV, 32'hFFFF_FF00, 32'd0);
        checkOutput("div by zero neg value", {bus.hi, bus.lo}, 64'hFFFF_FF00_FFFF_FFFF);

        applyStimulus(OP_MTHI, 32'hDEAD, 32'd0);
        checkOutput("mthi hi", 64'(bus.hi), 64'hDEAD);
        checkOutput("mthi busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi done", 64'(bus.done), 64'd0);
        applyStimulus(OP_MTLO, 32'hBEEF, 32'd0);
        checkOutput("mtlo hi/lo", {bus.hi, bus.lo}, 64'h0000_DEAD_0000_BEEF);
        applyStimulus(3'd7, 32'h1111, 32'h2222);
        checkOutput("reserved op", {bus.hi, bus.lo, 31'd0, bus.busy}, {64'h0000_DEAD_0000_BEEF, 32'd0});

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = rb >> $urandom_range(16, 31);
            runOp("random", rop, ra, rb);
        end

        // MTLO issued while a MULT is in flight is dropped; second MULT issues on the done cycle.
        oldLo    = bus.lo;
        firstRes = model(OP_MULT, 32'h1234_5678, 32'h8765_4321);
        applyStimulus(OP_MULT, 32'h1234_5678, 32'h8765_4321);
        repeat (9) tick();
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.A     = 32'h5555_AAAA;
        tick();
        bus.start = 1'b0;
        checkOutput("mtlo while busy lo held", 64'(bus.lo), 64'(oldLo));
        checkOutput("mtlo while busy busy", 64'(bus.busy), 64'd1);
        waitDone("b2b first", n);
        checkOutput("b2b first lo", 64'(bus.lo), 64'(firstRes[31:0]));
        applyStimulus(OP_MULT, 32'hFFFF_0001, 32'd3);
        checkOutput("b2b second accepted", 64'(bus.busy), 64'd1);
        waitDone("b2b second", n);
        checkOutput("b2b second latency", 64'(n), 64'd33);
        tick();

        // Reset mid-DIV aborts the op and no result is ever written.
        applyStimulus(OP_DIV, 32'h7FFF_0000, 32'd7);
        repeat (14) tick();
        reset = 1'b1;
        expQ.delete();
        tick();
        reset = 1'b0;
        checkOutput("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) doneCount++;
        end
        checkOutput("abort no done", 64'(doneCount), 64'd0);
        checkOutput("abort hi/lo hold", {bus.hi, bus.lo}, 64'd0);

        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
